// File: rtl/interfpga_rx_fifo_pkg.sv
// Definitions shared by both ends of the 4-bit inter-FPGA nibble link.
package interfpga_pkg;
  localparam int NIBBLE_W  = 4;
  localparam int FRAME_LEN = 4;

  // Frame decoder position: IDLE waits for ctrl, C1..C3 count the remaining hold cycles.
  typedef enum logic [1:0] {IDLE, C1, C2, C3} state_t;
endpackage

// File: rtl/interfpga_rx_fifo_if.sv
// Byte stream from the receive FIFO to local logic.
// valid/ready: a byte transfers on a clock edge where m_valid & m_ready are both high;
// m_data/m_valid change only on clock edges and m_valid never depends on m_ready.
interface interfpga_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/interfpga_sync_fifo.sv
// Single-clock show-ahead FIFO; a pop frees a slot for a push in the same cycle.
module interfpga_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW:0]   count_next
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/interfpga_rx_fifo.sv
// Receive endpoint of the nibble link: registers the pins, decodes 4-cycle frames
// into bytes, buffers them and raises hold_o before the buffer runs out of room.
module interfpga_rx_fifo
    import interfpga_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int HOLD_MARGIN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NIBBLE_W-1:0] data_i,
    input  logic                ctrl_i,
    output logic                hold_o,
    interfpga_rx_fifo_if.master m_if,
    output logic [AW:0]         count,
    output logic                overflow,
    output logic                frame_err,
    input  logic                clear_err,
    output state_t              fsm_state
);
    logic [NIBBLE_W-1:0] data_q;
    logic                ctrl_q;
    logic [NIBBLE_W-1:0] lo;
    state_t              state;
    state_t              state_next;
    logic                lo_load;
    logic                push;
    logic                err_set;
    logic                pop;
    logic                full;
    logic                empty;
    logic [AW:0]         count_next;

    assign fsm_state    = state;
    assign pop          = m_if.m_valid & m_if.m_ready;
    assign m_if.m_valid = ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            ctrl_q <= 1'b0;
            state  <= IDLE;
            lo     <= '0;
        end else begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
            state  <= state_next;
            if (lo_load) lo <= data_q;
        end
    end

    // Nibbles are taken at C1 and C3, i.e. the second cycle of each 2-cycle hold.
    always_comb begin
        state_next = state;
        lo_load    = 1'b0;
        push       = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: if (ctrl_q) state_next = C1;
            C1: begin
                if (ctrl_q) begin
                    lo_load    = 1'b1;
                    state_next = C2;
                end else begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            C2: begin
                if (ctrl_q) state_next = C3;
                else begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            C3: begin
                if (ctrl_q) push = 1'b1;
                else        err_set = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    interfpga_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .W(8)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wdata      ({data_q, lo}),
        .pop        (pop),
        .rdata      (m_if.m_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .count_next (count_next)
    );

    // clear_err wins over a set arriving on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
            hold_o    <= 1'b0;
        end else begin
            if (clear_err) begin
                overflow  <= 1'b0;
                frame_err <= 1'b0;
            end else begin
                if (err_set)               frame_err <= 1'b1;
                if (push & full & ~pop)    overflow  <= 1'b1;
            end
            hold_o <= (count_next >= (AW+1)'(DEPTH - HOLD_MARGIN));
        end
    end
endmodule

// File: tb/tb_interfpga_rx_fifo.sv
// Bench for interfpga_rx_fifo: directed link frames plus random traffic, checked
// against a queue model in which each complete frame lands 4 edges after it starts.
module tb_interfpga_rx_fifo;
  import interfpga_pkg::*;

  localparam int DEPTH       = 16;
  localparam int AW          = 4;
  localparam int HOLD_MARGIN = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    data_i;
  logic          ctrl_i;
  logic          hold_o;
  logic [AW:0]   count;
  logic          overflow;
  logic          frame_err;
  logic          clear_err;
  state_t        fsm_state;

  interfpga_rx_fifo_if m_if ();

  interfpga_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .HOLD_MARGIN(HOLD_MARGIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_i    (data_i),
    .ctrl_i    (ctrl_i),
    .hold_o    (hold_o),
    .m_if      (m_if.master),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clear_err (clear_err),
    .fsm_state (fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int         at_edge;
    logic [7:0] b;
  } push_t;

  push_t      sched[$];
  int         err_sched[$];
  logic [7:0] exp_q[$];
  logic       exp_ovf  = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_hold = 1'b0;

  // scoreboard model: scheduled bytes and errors applied on their edge
  always @(posedge clk) begin
    push_t p;
    cyc = cyc + 1;
    if (reset) begin
      exp_q.delete();
      sched.delete();
      err_sched.delete();
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
    end else begin
      if (exp_q.size() != 0 && m_if.m_ready) void'(exp_q.pop_front());
      if (sched.size() != 0 && sched[0].at_edge == cyc) begin
        p = sched.pop_front();
        if (exp_q.size() < DEPTH) exp_q.push_back(p.b);
        else                      exp_ovf = 1'b1;
      end
      if (err_sched.size() != 0 && err_sched[0] == cyc) begin
        void'(err_sched.pop_front());
        exp_ferr = 1'b1;
      end
      if (clear_err) begin
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
      end
    end
    exp_hold = (exp_q.size() >= DEPTH - HOLD_MARGIN);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_count"},    32'(count),        32'(exp_q.size()));
    chk({tag, "_valid"},    32'(m_if.m_valid), 32'(exp_q.size() != 0));
    chk({tag, "_hold"},     32'(hold_o),       32'(exp_hold));
    chk({tag, "_overflow"}, 32'(overflow),     32'(exp_ovf));
    chk({tag, "_frame_err"},32'(frame_err),    32'(exp_ferr));
    if (exp_q.size() != 0) chk({tag, "_data"}, 32'(m_if.m_data), 32'(exp_q[0]));
  endtask

  always @(negedge clk) if (mon_en) check_outputs("cycle");

  // driver tasks
  task automatic send_frame(input logic [7:0] b);
    @(negedge clk);
    sched.push_back('{at_edge: cyc + 5, b: b});
    ctrl_i = 1'b1; data_i = b[3:0];
    @(negedge clk); data_i = b[3:0];
    @(negedge clk); data_i = b[7:4];
    @(negedge clk); data_i = b[7:4];
  endtask

  task automatic short_frame();
    @(negedge clk);
    err_sched.push_back(cyc + 4);
    ctrl_i = 1'b1; data_i = 4'($urandom_range(0, 15));
    @(negedge clk); data_i = 4'($urandom_range(0, 15));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ctrl_i = 1'b0;
      data_i = 4'($urandom_range(0, 15));
    end
  endtask

  // finish the current frame with a low cycle and sample just after its push edge
  task automatic end_frame_and_sample();
    @(negedge clk); ctrl_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_err = 1'b1;
    @(negedge clk); clear_err = 1'b0;
  endtask

  logic [7:0] vals [6];

  initial begin
    reset = 1'b1; ctrl_i = 1'b0; data_i = 4'h0; clear_err = 1'b0; m_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_hold",  32'(hold_o), 32'd0);
    chk("rst_flags", 32'({overflow, frame_err}), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    mon_en = 1'b1;

    // single frame, latency and pop
    send_frame(8'hA5);
    @(negedge clk); ctrl_i = 1'b0;
    chk("lat_before_e4", 32'(m_if.m_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(m_if.m_valid), 32'd1);
    chk("lat_data",  32'(m_if.m_data), 32'hA5);
    chk("lat_count", 32'(count), 32'd1);
    m_if.m_ready = 1'b1;
    @(negedge clk); m_if.m_ready = 1'b0;
    chk("pop_count", 32'(count), 32'd0);
    chk("pop_valid", 32'(m_if.m_valid), 32'd0);

    // fill to full with 1-cycle gaps, hold rises as count reaches 12
    for (int i = 1; i <= 16; i++) begin
      send_frame(8'(i));
      end_frame_and_sample();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_hold",  32'(hold_o), 32'(i >= 12));
    end
    send_frame(8'h11);
    end_frame_and_sample();
    chk("full_count", 32'(count), 32'd16);
    chk("full_overflow", 32'(overflow), 32'd1);
    @(negedge clk); m_if.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_data", 32'(m_if.m_data), 32'(i));
      @(negedge clk);
    end
    m_if.m_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    pulse_clear();
    chk("clr_overflow", 32'(overflow), 32'd0);

    // truncated frame, then a good one
    short_frame();
    idle(4);
    chk("short_ferr",  32'(frame_err), 32'd1);
    chk("short_count", 32'(count), 32'd0);
    send_frame(8'h3C);
    end_frame_and_sample();
    chk("after_err_data",  32'(m_if.m_data), 32'h3C);
    chk("after_err_count", 32'(count), 32'd1);
    pulse_clear();
    chk("clr_flags", 32'({overflow, frame_err}), 32'd0);
    m_if.m_ready = 1'b1;
    @(negedge clk); m_if.m_ready = 1'b0;

    // push and pop on the same edge with count 5
    for (int i = 0; i < 6; i++) vals[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      send_frame(vals[i]);
      idle(1);
    end
    idle(1);
    chk("pp_pre_count", 32'(count), 32'd5);
    send_frame(vals[5]);
    @(negedge clk); ctrl_i = 1'b0; m_if.m_ready = 1'b1;
    @(posedge clk); #1;
    chk("pp_count", 32'(count), 32'd5);
    @(negedge clk); m_if.m_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      chk("pp_order", 32'(m_if.m_data), 32'(vals[i]));
      @(negedge clk);
    end
    m_if.m_ready = 1'b0;

    // zero-gap frames
    send_frame(8'h12);
    send_frame(8'h34);
    idle(3);
    chk("zg_count", 32'(count), 32'd2);
    chk("zg_first", 32'(m_if.m_data), 32'h12);
    m_if.m_ready = 1'b1;
    @(negedge clk); m_if.m_ready = 1'b0;
    chk("zg_second", 32'(m_if.m_data), 32'h34);
    m_if.m_ready = 1'b1;
    @(negedge clk); m_if.m_ready = 1'b0;

    // reset while the decoder sits in C2
    @(negedge clk); ctrl_i = 1'b1; data_i = 4'h9;
    @(negedge clk); data_i = 4'h9;
    @(negedge clk); data_i = 4'h6;
    chk("c2_state", 32'(fsm_state), 32'(C1));
    @(negedge clk); ctrl_i = 1'b0; reset = 1'b1;
    chk("c2_state_b", 32'(fsm_state), 32'(C2));
    @(negedge clk); reset = 1'b0;
    idle(3);
    chk("rst_c2_count", 32'(count), 32'd0);
    send_frame(8'h77);
    end_frame_and_sample();
    chk("post_rst_data",  32'(m_if.m_data), 32'h77);
    chk("post_rst_count", 32'(count), 32'd1);

    // random traffic with random gaps and consumer stalls
    for (int i = 0; i < 40; i++) begin
      int gap;
      m_if.m_ready = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)));
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(1);
    m_if.m_ready = 1'b1;
    idle(24);
    chk("rand_drained", 32'(count), 32'd0);
    pulse_clear();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
